// File: rtl/flopr_pkg.sv
// Shared constants, types and elaboration checks for the flopr enable register.
package flopr_pkg;

  localparam int FLOPR_DEFAULT_WIDTH = 32;

  typedef logic [FLOPR_DEFAULT_WIDTH-1:0] flopr_word_t;

  function automatic bit flopr_width_ok(input int width);
    return (width >= 1) && (width <= 1024);
  endfunction

endpackage

// File: rtl/flopr_bit.sv
// Single-bit rising-edge flop with asynchronous active-low clear to a per-bit value and load enable.
module flopr_bit #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      q <= RESET_VALUE;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/flopr.sv
// WIDTH-bit enable register with async active-low clear, built from per-bit flops.
// Optional checking block compiled in when FLOPR_ASSERTIONS_EN is defined.
module flopr
  import flopr_pkg::*;
#(
  parameter int               WIDTH       = FLOPR_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (!flopr_width_ok(WIDTH)) begin : g_bad_width
    $error("flopr: WIDTH must be in 1..1024");
  end

  // One cell per bit so each bit can carry its own reset value.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    flopr_bit #(
      .RESET_VALUE(RESET_VALUE[i])
    ) u_bit (
      .clk  (clk),
      .reset(reset),
      .en   (en),
      .d    (d[i]),
      .q    (q[i])
    );
  end

`ifdef FLOPR_ASSERTIONS_EN
  a_en_known : assert property (@(posedge clk) disable iff (!reset)
    !$isunknown(en));

  a_d_known : assert property (@(posedge clk) disable iff (!reset)
    en |-> !$isunknown(d));

  a_load : assert property (@(posedge clk) disable iff (!reset)
    en |=> (q == $past(d)));

  a_hold : assert property (@(posedge clk) disable iff (!reset)
    !en |=> $stable(q));

  always @(posedge clk) begin
    if (!reset) begin
      a_reset_value : assert (q == RESET_VALUE);
    end
  end

  c_load  : cover property (@(posedge clk) disable iff (!reset) en);
  c_hold  : cover property (@(posedge clk) disable iff (!reset) !en);
  c_reset : cover property (@(posedge clk) !reset && en);
`endif

endmodule

// File: tb/tb_flopr.sv
// Directed self-checking bench for flopr: default 32-bit instance plus an 8-bit, 0x5A-reset variant.
module tb_flopr;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [31:0] d;
  logic [31:0] q;
  logic        en8;
  logic [7:0]  d8;
  logic [7:0]  q8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flopr dut (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .d    (d),
    .q    (q)
  );

  flopr #(
    .WIDTH      (8),
    .RESET_VALUE(8'h5A)
  ) dut8 (
    .clk  (clk),
    .reset(reset),
    .en   (en8),
    .d    (d8),
    .q    (q8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle at the falling edge for sampling and driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] d;
    logic        en;
    logic [31:0] q;
  } vec_t;

  vec_t vecs[5] = '{
    '{32'd3,  1'b1, 32'd3},
    '{32'd7,  1'b0, 32'd3},
    '{32'd9,  1'b1, 32'd9},
    '{32'd15, 1'b1, 32'd15},
    '{32'd2,  1'b0, 32'd15}
  };

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    en    = 1'b1;
    d     = 32'hFFFF_FFFF;
    en8   = 1'b1;
    d8    = 8'hFF;
    @(negedge clk);
    check("reset_q_c0", q, 32'h0);
    check("reset_q8_c0", {24'h0, q8}, 32'h5A);
    tick();
    check("reset_q_c1", q, 32'h0);
    check("reset_q8_c1", {24'h0, q8}, 32'h5A);

    reset = 1'b1;
    d     = 32'h0000_00A5;
    en8   = 1'b0;
    tick();
    check("load_1", q, 32'h0000_00A5);
    check("q8_hold_after_reset", {24'h0, q8}, 32'h5A);
    tick();
    check("load_2", q, 32'h0000_00A5);

    en = 1'b0;
    d  = 32'h1234_5678;
    tick();
    check("hold_1", q, 32'h0000_00A5);
    tick();
    check("hold_2", q, 32'h0000_00A5);
    en = 1'b1;
    tick();
    check("reload", q, 32'h1234_5678);

    d   = 32'hDEAD_BEEF;
    en8 = 1'b1;
    d8  = 8'hC3;
    tick();
    check("load_beef", q, 32'hDEAD_BEEF);
    check("q8_load_c3", {24'h0, q8}, 32'hC3);

    #2 reset = 1'b0;
    #1;
    check("async_clear", q, 32'h0);
    check("async_clear_q8", {24'h0, q8}, 32'h5A);
    d = 32'h1;
    @(negedge clk);
    tick();
    check("reset_en_1", q, 32'h0);
    tick();
    check("reset_en_2", q, 32'h0);
    check("reset_en_q8", {24'h0, q8}, 32'h5A);

    reset = 1'b1;
    en8   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d  = vecs[i].d;
      en = vecs[i].en;
      tick();
      tick();
      check($sformatf("seq_%0d", i), q, vecs[i].q);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
